// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: programmable serial-pattern detection controller.
// The host loads a PAT_W-bit pattern and a match quota while idle, then arms
// with start. In RUN the controller scans a qualified serial bit stream, flags
// every (overlapping) match on y in the cycle the last bit arrives, and counts
// matches. Reaching a non-zero quota produces a one-cycle DONE before the
// controller returns to IDLE.
//
// Ports:
//   cp          rising-edge clock
//   reset       asynchronous active-high reset
//   cfg_valid   load cfg_pat / cfg_target (IDLE only)
//   cfg_pat     target pattern, MSB is the first bit received
//   cfg_target  matches required before DONE, 0 = run until stop
//   start       IDLE -> RUN request
//   stop        abort RUN -> IDLE, overrides any match that cycle
//   x, x_valid  serial data bit and its qualifier
//   y           Mealy match flag (combinational)
//   match_cnt   saturating match count for the current/last run
//   busy        registered, high while in RUN
//   done        registered, high for the single DONE cycle
//   state       IDLE=0, RUN=1, DONE=2
module seq_detect_ctrl #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             cp,
  input  logic             reset,
  input  logic             cfg_valid,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             stop,
  input  logic             x,
  input  logic             x_valid,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  localparam int unsigned FILL_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [PAT_W-1:0]   pat;
  logic [CNT_W-1:0]   target;
  logic [PAT_W-2:0]   hist;
  logic [FILL_W-1:0]  fill;

  // Candidate window: previously accepted bits followed by the current bit.
  logic [PAT_W-1:0]   window;
  logic               quota_hit;

  assign window = {hist, x};

  // Mealy match: only once the history holds PAT_W-1 real bits, and stop wins.
  assign y = (state_q == RUN) & x_valid & ~stop & (fill == FILL_MAX) & (window == pat);

  // Compare one bit wider so a saturated counter still meets the quota.
  assign quota_hit = (target != '0) &&
                     (({1'b0, match_cnt} + (CNT_W+1)'(1)) >= {1'b0, target});

  assign state = state_q;

  // Controller state, configuration, detector history and counters.
  always_ff @(posedge cp or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pat       <= '0;
      target    <= '0;
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (cfg_valid) begin
            pat    <= cfg_pat;
            target <= cfg_target;
          end
          if (start) begin
            state_q   <= RUN;
            busy      <= 1'b1;
            match_cnt <= '0;
            hist      <= '0;
            fill      <= '0;
          end
        end

        RUN: begin
          if (stop) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end else begin
            if (x_valid) begin
              hist <= window[PAT_W-2:0];
              if (fill != FILL_MAX) fill <= fill + FILL_W'(1);
            end
            if (y) begin
              if (match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
              if (quota_hit) begin
                state_q <= DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end
            end
          end
        end

        DONE: begin
          state_q <= IDLE;
          done    <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: directed scenarios plus randomized
// traffic, compared against a bit-queue reference model of the controller.
module tb_seq_detect_ctrl;

  localparam int unsigned PAT_W   = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             cp;
  logic             reset;
  logic             cfg_valid;
  logic [PAT_W-1:0] cfg_pat;
  logic [CNT_W-1:0] cfg_target;
  logic             start;
  logic             stop;
  logic             x;
  logic             x_valid;
  logic             y;
  logic [CNT_W-1:0] match_cnt;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  int checks = 0;
  int errors = 0;

  // Reference model: run phase, config, count and recently accepted bits.
  int   m_state;
  int   m_pat;
  int   m_tgt;
  int   m_cnt;
  logic m_bits[$];

  seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .cp         (cp),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_pat    (cfg_pat),
    .cfg_target (cfg_target),
    .start      (start),
    .stop       (stop),
    .x          (x),
    .x_valid    (x_valid),
    .y          (y),
    .match_cnt  (match_cnt),
    .busy       (busy),
    .done       (done),
    .state      (state)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A match needs PAT_W-1 earlier bits of this run followed by the current bit.
  function automatic logic exp_y(input logic xb, input logic xv, input logic sp);
    int v;
    if (m_state != 1 || !xv || sp || m_bits.size() < PAT_W - 1) return 1'b0;
    v = 0;
    for (int i = m_bits.size() - (PAT_W - 1); i < m_bits.size(); i++)
      v = v * 2 + int'(m_bits[i]);
    v = v * 2 + int'(xb);
    return v == m_pat;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_pat   = 0;
    m_tgt   = 0;
    m_cnt   = 0;
    m_bits.delete();
  endtask

  // Inputs are already driven (clock low); check y, clock once, check state.
  task automatic cycle();
    logic ye;
    #1;
    ye = exp_y(x, x_valid, stop);
    check("y", 32'(y), 32'(ye));
    @(posedge cp);
    case (m_state)
      0: begin
        if (cfg_valid) begin
          m_pat = int'(cfg_pat);
          m_tgt = int'(cfg_target);
        end
        if (start) begin
          m_state = 1;
          m_cnt   = 0;
          m_bits.delete();
        end
      end
      1: begin
        if (stop) m_state = 0;
        else begin
          if (x_valid) begin
            m_bits.push_back(x);
            if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
          end
          if (ye) begin
            if (m_tgt != 0 && m_cnt + 1 >= m_tgt) m_state = 2;
            if (m_cnt < CNT_MAX) m_cnt++;
          end
        end
      end
      default: m_state = 0;
    endcase
    #1;
    check("state", 32'(state), 32'(m_state));
    check("busy", 32'(busy), 32'(m_state == 1));
    check("done", 32'(done), 32'(m_state == 2));
    check("match_cnt", 32'(match_cnt), 32'(m_cnt));
    @(negedge cp);
  endtask

  task automatic drive(input logic cv, input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] t,
                       input logic st, input logic sp, input logic xb, input logic xv);
    cfg_valid  = cv;
    cfg_pat    = p;
    cfg_target = t;
    start      = st;
    stop       = sp;
    x          = xb;
    x_valid    = xv;
    cycle();
  endtask

  task automatic arm(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] t);
    drive(1'b1, p, t, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic bit_in(input logic b);
    drive(1'b0, '0, '0, 1'b0, 1'b0, b, 1'b1);
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic abort();
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic feed(input logic [6:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) bit_in(bits[i]);
  endtask

  initial begin
    reset = 1'b1;
    cfg_valid = 1'b0; cfg_pat = '0; cfg_target = '0;
    start = 1'b0; stop = 1'b0; x = 1'b0; x_valid = 1'b0;
    model_reset();
    #2;
    check("rst_state", 32'(state), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cnt", 32'(match_cnt), 32'd0);
    repeat (3) @(negedge cp);
    reset = 1'b0;
    idle();

    // Overlapping matches, no quota: 1011 in 1011011.
    arm(4'b1011, 8'd0);
    feed(7'b1011011, 7);
    check("free_cnt", 32'(match_cnt), 32'd2);
    check("free_busy", 32'(busy), 32'd1);
    abort();

    // Quota of two ends the run with a one-cycle DONE.
    arm(4'b1011, 8'd2);
    feed(7'b1011011, 7);
    check("quota_done", 32'(done), 32'd1);
    idle();
    idle();
    check("quota_hold", 32'(match_cnt), 32'd2);

    // Invalid gaps do not break a partial match.
    arm(4'b1011, 8'd0);
    feed(7'b0000101, 3);
    repeat (3) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    bit_in(1'b1);
    check("gap_cnt", 32'(match_cnt), 32'd1);
    abort();

    // Config changes during RUN are ignored; stop overrides a completing bit.
    arm(4'b1011, 8'd0);
    for (int i = 0; i < 6; i++) begin
      logic [5:0] s;
      s = 6'b101101;
      drive(1'b1, 4'b0110, 8'd1, 1'b1, 1'b0, s[5-i], 1'b1);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("stop_cnt", 32'(match_cnt), 32'd1);
    idle();

    // Asynchronous reset mid-run clears everything before the next edge.
    arm(4'b1011, 8'd3);
    feed(7'b1011011, 6);
    x = 1'b1; x_valid = 1'b1; reset = 1'b1;
    #1;
    check("arst_y", 32'(y), 32'd0);
    check("arst_cnt", 32'(match_cnt), 32'd0);
    check("arst_state", 32'(state), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    model_reset();
    @(posedge cp);
    #1;
    check("arst_done", 32'(done), 32'd0);
    @(negedge cp);
    reset = 1'b0;
    idle();
    // Pattern register was cleared, so start alone detects 0000.
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    feed(7'b0000000, 5);
    check("arst_pat", 32'(match_cnt), 32'd2);
    abort();

    // Counter saturation with no quota.
    arm(4'b1111, 8'd0);
    repeat (262) bit_in(1'b1);
    check("sat_cnt", 32'(match_cnt), 32'(CNT_MAX));
    abort();

    // All-ones quota still terminates.
    arm(4'b1111, 8'(CNT_MAX));
    for (int i = 0; i < 300 && m_state == 1; i++) bit_in(1'b1);
    check("sat_quota", 32'(m_state), 32'd2);
    idle();

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom % 8) == 0, PAT_W'($urandom), CNT_W'($urandom % 6),
            ($urandom % 4) == 0, ($urandom % 32) == 0,
            1'($urandom), ($urandom % 4) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Programmable serial-pattern detection controller clocked on `cp`. It loads a PAT_W-bit target pattern and a match quota, arms on `start`, and scans a qualified serial bit stream with a Mealy-style output `y`. It counts overlapping matches and finishes with a one-cycle `done` once the quota is met. It sequences the bit-serial sequence-detector datapath so a host can reconfigure and rerun it without resetting the design.

## Interface
- PAT_W, 4, pattern length in bits (fixed length, ≥2)
- CNT_W, 8, width of match counter and quota
- cp  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- cfg_valid  in  1  load cfg_pat/cfg_target (honoured in IDLE only)
- cfg_pat  in  PAT_W  pattern; MSB is the first bit received
- cfg_target  in  CNT_W  matches required before DONE; 0 = run until stop
- start  in  1  IDLE→RUN request
- stop  in  1  abort RUN→IDLE
- x  in  1  serial data bit
- x_valid  in  1  x is consumed this cycle
- y  out  1  Mealy match flag (combinational)
- match_cnt  out  CNT_W  matches counted in current/last run
- busy  out  1  state==RUN
- done  out  1  high exactly one cycle (state==DONE)
- state  out  2  IDLE=0, RUN=1, DONE=2 (3 unused → IDLE)

## Operation
- Reset state, asserted asynchronously: state IDLE, pat 0, target 0, history 0, fill 0, match_cnt 0. Outputs y, busy and done are 0.
- Internal regs: pat[PAT_W], target[CNT_W], hist[PAT_W-1] (last valid bits, newest in LSB), fill counter saturating at PAT_W-1.
- IDLE:
  - cfg_valid loads pat and target.
  - start (with or without cfg_valid) → RUN. If both are asserted, the new config is used.
  - On entry to RUN: match_cnt←0, hist←0, fill←0.
  - x/x_valid ignored.
- RUN:
  - y = x_valid & ~stop & (fill==PAT_W-1) & ({hist,x}==pat).
  - On x_valid: hist shifts left taking x; fill increments (saturating).
  - On y: match_cnt increments, saturating at 2^CNT_W-1.
  - Overlapping matches count: history is not cleared after a match.
  - If y and target≠0 and match_cnt+1 ≥ target → DONE.
  - stop → IDLE. Stop has priority: y is forced 0 and no count or shift happens that cycle.
  - cfg_valid and start are ignored.
- DONE: lasts one cycle, then returns unconditionally to IDLE. Inputs are ignored.
- match_cnt holds its value in IDLE and DONE until the next start.
- x_valid low in RUN: no shift, no count, y=0.

## Timing
- y is asserted in the same cycle the final pattern bit is presented with x_valid. match_cnt updates at the next cp edge.
- Quota-reaching match at edge N: state=DONE and done=1 during cycle N+1, IDLE at edge N+2. The earliest restart is start sampled in the first IDLE cycle.
- start → busy high from the next edge. The first bit can be consumed in that first RUN cycle.
- Minimum detection after start: PAT_W valid bits. Bits arriving before fill saturates never produce y.
- reset mid-RUN or mid-DONE: all registers clear immediately. done is never emitted for that run, and the config must be reloaded.
- Counter saturation: match_cnt stays at all-ones. The DONE check uses ≥, so target=2^CNT_W-1 still terminates.

## Test plan
- Reset at t=0 for 30 ns, cfg_pat=1011, cfg_target=0, start, stream 1,0,1,1,0,1,1 all valid → y high on the 4th and 7th bits, match_cnt=2, busy stays 1.
- Same pattern with cfg_target=2 → after the 7th bit, state=2 with done=1 for exactly one cycle, then state=0, busy=0, match_cnt holds 2.
- Stream 1,0,1 then x_valid low 3 cycles then 1 → gaps do not break the match: single y on the final bit, match_cnt=1.
- stop asserted in the same cycle as the completing bit → y=0, match_cnt unchanged, state→0. cfg_valid with pat=0110 during RUN has no effect on detection.
- reset pulsed mid-run after 1 match → match_cnt=0, state=0, y=0 immediately (before the next cp edge), no done pulse.
- CNT_W=2, cfg_target=0, pattern 11, stream of 6 ones → match_cnt saturates at 3, y high on bits 2–6.
